// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the shared SDRAM port.
// Handshake: rd/wr are held until the one-cycle ac pulse; wait is a stall hint, ac alone completes.
interface sdram_port_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 22,
    parameter int DATA_W = 128
);
    logic [NREQ-1:0]        req_rd;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ-1:0]        req_busy;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wrdata;
    logic [NREQ-1:0]        req_wait;
    logic [NREQ-1:0]        req_ac;
    logic [DATA_W-1:0]      req_rddata;
    logic [NREQ-1:0]        grant;
    logic                   sdram_rd;
    logic                   sdram_wr;
    logic [ADDR_W-1:0]      sdram_addr;
    logic [DATA_W-1:0]      sdram_wrdata;
    logic                   sdram_wait;
    logic                   sdram_ac;
    logic [DATA_W-1:0]      sdram_rddata;

    // Arbiter view.
    modport slave (
        input  req_rd, req_wr, req_busy, req_addr, req_wrdata,
        input  sdram_wait, sdram_ac, sdram_rddata,
        output req_wait, req_ac, req_rddata, grant,
        output sdram_rd, sdram_wr, sdram_addr, sdram_wrdata
    );

    // Environment view: requesters plus controller.
    modport master (
        output req_rd, req_wr, req_busy, req_addr, req_wrdata,
        output sdram_wait, sdram_ac, sdram_rddata,
        input  req_wait, req_ac, req_rddata, grant,
        input  sdram_rd, sdram_wr, sdram_addr, sdram_wrdata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among NREQ masters: requester 0 (display) has absolute
// priority, engines rotate round-robin, ownership moves only at transaction boundaries.
module sdram_port_arbiter #(
    parameter int NREQ     = 3,
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 128,
    parameter int MAX_HOLD = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    sdram_port_arbiter_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [IDX_W-1:0]  rr_q, rr_d;

    logic [NREQ-1:0]   want;
    logic [NREQ-1:0]   eng_mask;
    logic [IDX_W-1:0]  winner, idx;
    logic              found;
    logic              any_want, own_want, owner_is_eng, engine_peer;
    logic              boundary, leave;

    assign want         = bus.req_rd | bus.req_wr | bus.req_busy;
    assign eng_mask     = {{(NREQ-1){1'b1}}, 1'b0};
    assign any_want     = |want;
    assign own_want     = |(want & grant_q);
    assign owner_is_eng = |(grant_q & eng_mask);
    assign engine_peer  = |(want & ~grant_q & eng_mask);
    assign boundary     = ~|((bus.req_rd | bus.req_wr) & grant_q);

    // The ac of the current cycle is counted before the hold limit is judged.
    assign hold_inc = (bus.sdram_ac && hold_q != HOLD_W'(MAX_HOLD)) ? hold_q + 1'b1 : hold_q;

    assign leave = boundary && (!own_want ||
                                (owner_is_eng && want[0]) ||
                                (owner_is_eng && hold_inc == HOLD_W'(MAX_HOLD) && engine_peer));

    // Display first, otherwise first wanting engine upward from rr_q, wrapping to 1.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = rr_q;
        if (want[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                if (!found && want[idx]) begin
                    found  = 1'b1;
                    winner = idx;
                end
                idx = (idx == IDX_W'(NREQ - 1)) ? IDX_W'(1) : idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        rr_d    = rr_q;
        case (state_q)
            OWN: begin
                hold_d = hold_inc;
                if (leave) begin
                    state_d = GAP;
                    grant_d = '0;
                end
            end
            default: begin
                if (any_want) begin
                    state_d = OWN;
                    grant_d = NREQ'(1) << winner;
                    hold_d  = '0;
                    if (winner != '0)
                        rr_d = (winner == IDX_W'(NREQ - 1)) ? IDX_W'(1) : winner + 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            hold_q  <= '0;
            rr_q    <= IDX_W'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            rr_q    <= rr_d;
        end
    end

    // Datapath steered purely by the registered grant; zero grant parks everything.
    always_comb begin
        bus.sdram_addr   = '0;
        bus.sdram_wrdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                bus.sdram_addr   = bus.req_addr[i*ADDR_W +: ADDR_W];
                bus.sdram_wrdata = bus.req_wrdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.sdram_rd   = |(bus.req_rd & grant_q);
    assign bus.sdram_wr   = |(bus.req_wr & grant_q);
    assign bus.req_wait   = ~grant_q | (grant_q & {NREQ{bus.sdram_wait}});
    assign bus.req_ac     = grant_q & {NREQ{bus.sdram_ac}};
    assign bus.req_rddata = bus.sdram_rddata;
    assign bus.grant      = grant_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with MAX_HOLD=4; expected values are hand-derived.
module tb_sdram_port_arbiter;
    localparam int NREQ     = 3;
    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 128;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;
    int         tests = 0;
    int         fails = 0;

    sdram_port_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sdram_port_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One read by requester i: strobe cycle, ac cycle, then strobe dropped in the following cycle.
    task automatic txn(input int i, input logic [ADDR_W-1:0] a);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << i;
        bus.req_rd[i] = 1'b1;
        bus.req_addr[i*ADDR_W +: ADDR_W] = a;
        bus.sdram_ac = 1'b0;
        settle();
        chk("txn_rd", bus.sdram_rd, 1);
        chk("txn_addr", bus.sdram_addr, a);
        tick();
        bus.sdram_ac = 1'b1;
        settle();
        chk("txn_ac", bus.req_ac, oh);
        tick();
        bus.req_rd[i] = 1'b0;
        bus.sdram_ac  = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        bus.req_rd       = '0;
        bus.req_wr       = '0;
        bus.req_busy     = '0;
        bus.req_addr     = '0;
        bus.req_wrdata   = '0;
        bus.sdram_wait   = 1'b0;
        bus.sdram_ac     = 1'b0;
        bus.sdram_rddata = '0;

        // Reset state, including an ac pulse that must not be forwarded.
        tick();
        tick();
        bus.sdram_ac = 1'b1;
        settle();
        chk("rst_grant", bus.grant, 3'b000);
        chk("rst_wait", bus.req_wait, 3'b111);
        chk("rst_rd", bus.sdram_rd, 0);
        chk("rst_wr", bus.sdram_wr, 0);
        chk("rst_addr", bus.sdram_addr, 0);
        chk("rst_wrdata", bus.sdram_wrdata, 0);
        chk("rst_ac", bus.req_ac, 3'b000);
        chk("rst_state", dbg_state, 2'd0);
        bus.sdram_ac = 1'b0;
        reset = 1'b1;
        tick();

        // Idle: ac ignored, read data broadcast.
        bus.sdram_ac     = 1'b1;
        bus.sdram_rddata = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        settle();
        chk("idle_ac", bus.req_ac, 3'b000);
        chk("idle_rddata", bus.req_rddata, 128'hdead_beef_0000_1111_2222_3333_4444_5555);
        bus.sdram_ac = 1'b0;

        // Single engine: read then write.
        bus.req_busy[1] = 1'b1;
        bus.req_rd[1]   = 1'b1;
        bus.req_addr[1*ADDR_W +: ADDR_W] = 22'h12345;
        settle();
        chk("se_grant_t0", bus.grant, 3'b000);
        chk("se_rd_t0", bus.sdram_rd, 0);
        tick();
        chk("se_grant_t1", bus.grant, 3'b010);
        chk("se_rd_t1", bus.sdram_rd, 1);
        chk("se_addr", bus.sdram_addr, 22'h12345);
        chk("se_state_own", dbg_state, 2'd1);
        chk("se_wait_low", bus.req_wait, 3'b101);
        bus.sdram_wait = 1'b1;
        settle();
        chk("se_wait_high", bus.req_wait, 3'b111);
        bus.sdram_wait = 1'b0;
        tick();
        tick();
        bus.sdram_ac     = 1'b1;
        bus.sdram_rddata = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        settle();
        chk("se_rd_ac", bus.req_ac, 3'b010);
        chk("se_rddata", bus.req_rddata, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210);
        tick();
        bus.sdram_ac  = 1'b0;
        bus.req_rd[1] = 1'b0;
        bus.req_wr[1] = 1'b1;
        bus.req_addr[1*ADDR_W +: ADDR_W]   = 22'h3abcd;
        bus.req_wrdata[1*DATA_W +: DATA_W] = 128'hcafe_f00d_0000_0000_0000_0000_a5a5_5a5a;
        settle();
        chk("se_wr", bus.sdram_wr, 1);
        chk("se_rd_off", bus.sdram_rd, 0);
        chk("se_wr_addr", bus.sdram_addr, 22'h3abcd);
        chk("se_wrdata", bus.sdram_wrdata, 128'hcafe_f00d_0000_0000_0000_0000_a5a5_5a5a);
        tick();
        tick();
        bus.sdram_ac = 1'b1;
        settle();
        chk("se_wr_ac", bus.req_ac, 3'b010);
        tick();
        bus.sdram_ac    = 1'b0;
        bus.req_wr[1]   = 1'b0;
        bus.req_busy[1] = 1'b0;
        settle();
        chk("se_grant_last", bus.grant, 3'b010);
        tick();
        chk("se_gap_grant", bus.grant, 3'b000);
        chk("se_gap_state", dbg_state, 2'd2);
        chk("se_gap_wait", bus.req_wait, 3'b111);
        chk("se_gap_wr", bus.sdram_wr, 0);
        tick();
        chk("se_idle_state", dbg_state, 2'd0);

        // Round-robin, pointer now at 2: owner order 2,1,2.
        bus.req_busy[1] = 1'b1;
        bus.req_busy[2] = 1'b1;
        tick();
        chk("rr_first", bus.grant, 3'b100);
        for (int n = 0; n < MAX_HOLD; n++) txn(2, 22'h20000 + 22'(n));
        bus.req_rd[1] = 1'b1;
        settle();
        chk("rr_bound_grant", bus.grant, 3'b100);
        chk("rr_bound_rd", bus.sdram_rd, 0);
        tick();
        chk("rr_gap1_grant", bus.grant, 3'b000);
        chk("rr_gap1_rd", bus.sdram_rd, 0);
        chk("rr_gap1_wait", bus.req_wait, 3'b111);
        chk("rr_gap1_state", dbg_state, 2'd2);
        tick();
        chk("rr_second", bus.grant, 3'b010);
        chk("rr_second_rd", bus.sdram_rd, 1);
        for (int n = 0; n < MAX_HOLD; n++) txn(1, 22'h10000 + 22'(n));
        settle();
        chk("rr_bound2", bus.grant, 3'b010);
        tick();
        chk("rr_gap2", bus.grant, 3'b000);
        tick();
        chk("rr_third", bus.grant, 3'b100);
        bus.req_busy[2] = 1'b0;
        tick();
        chk("rr_drop_gap", bus.grant, 3'b000);
        tick();
        chk("rr_back_to_1", bus.grant, 3'b010);

        // Display preemption while engine 1 holds a read.
        bus.req_rd[1] = 1'b1;
        bus.req_addr[1*ADDR_W +: ADDR_W] = 22'h0beef;
        bus.req_busy[0] = 1'b1;
        settle();
        chk("pre_grant", bus.grant, 3'b010);
        chk("pre_wait", bus.req_wait, 3'b101);
        tick();
        chk("pre_held", bus.grant, 3'b010);
        bus.sdram_ac = 1'b1;
        settle();
        chk("pre_ac", bus.req_ac, 3'b010);
        tick();
        bus.sdram_ac  = 1'b0;
        bus.req_rd[1] = 1'b0;
        settle();
        chk("pre_bound", bus.grant, 3'b010);
        tick();
        chk("pre_gap", bus.grant, 3'b000);
        tick();
        chk("pre_disp", bus.grant, 3'b001);
        chk("pre_eng_wait", bus.req_wait, 3'b110);
        bus.sdram_wait = 1'b1;
        settle();
        chk("pre_cwait", bus.req_wait, 3'b111);
        bus.sdram_wait = 1'b0;
        for (int n = 0; n < MAX_HOLD + 1; n++) txn(0, 22'h00100 + 22'(n));
        tick();
        chk("disp_no_preempt", bus.grant, 3'b001);
        bus.req_busy[0] = 1'b0;
        tick();
        chk("disp_gap", bus.grant, 3'b000);
        tick();
        chk("disp_eng_back", bus.grant, 3'b010);

        // Hold limit reached while a write awaits its ac.
        bus.req_busy[2] = 1'b1;
        for (int n = 0; n < MAX_HOLD; n++) txn(1, 22'h11000 + 22'(n));
        bus.req_wr[1] = 1'b1;
        bus.req_wrdata[1*DATA_W +: DATA_W] = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
        settle();
        chk("hold_wr", bus.sdram_wr, 1);
        chk("hold_grant0", bus.grant, 3'b010);
        tick();
        chk("hold_grant1", bus.grant, 3'b010);
        tick();
        chk("hold_grant2", bus.grant, 3'b010);
        bus.sdram_ac = 1'b1;
        settle();
        chk("hold_ac", bus.req_ac, 3'b010);
        tick();
        bus.sdram_ac  = 1'b0;
        bus.req_wr[1] = 1'b0;
        settle();
        chk("hold_bound", bus.grant, 3'b010);
        tick();
        chk("hold_gap", bus.grant, 3'b000);
        tick();
        chk("hold_next", bus.grant, 3'b100);

        // Reset during an active read by engine 2.
        bus.req_rd[2] = 1'b1;
        bus.req_addr[2*ADDR_W +: ADDR_W] = 22'h2f0f0;
        settle();
        chk("mrst_rd_before", bus.sdram_rd, 1);
        reset = 1'b0;
        tick();
        chk("mrst_grant", bus.grant, 3'b000);
        chk("mrst_rd", bus.sdram_rd, 0);
        chk("mrst_wait", bus.req_wait, 3'b111);
        chk("mrst_state", dbg_state, 2'd0);
        reset = 1'b1;
        tick();
        chk("mrst_rr", bus.grant, 3'b010);

        bus.req_rd   = '0;
        bus.req_busy = '0;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single 128-bit SDRAM controller port between NREQ masters: requester 0 is the display/scanout refill; requesters 1..NREQ-1 are copy engines such as the lane-background blitter and the note blitter.
- Each master keeps its existing rd/wr/wait/ac/busy handshake unchanged. The arbiter grants one owner at a time and multiplexes that owner onto the controller.
- Ownership changes only at transaction boundaries, with a one-cycle dead slot between owners.

Parameters:
- NREQ, 3, number of requesters (2..8).
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 128, SDRAM data width.
- MAX_HOLD, 64, completed transactions (sdram_ac pulses) an engine owner may perform before it must yield to a waiting peer.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_rd  in  NREQ  per-requester read strobe, held until its ac.
- req_wr  in  NREQ  per-requester write strobe, held until its ac.
- req_busy  in  NREQ  requester wants or keeps the port.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wrdata  in  NREQ*DATA_W  packed write data.
- req_wait  out  NREQ  per-requester wait.
- req_ac  out  NREQ  per-requester accept pulse.
- req_rddata  out  DATA_W  read data, broadcast to all requesters.
- grant  out  NREQ  one-hot current owner; all zero when no owner.
- sdram_rd  out  1  read strobe to the controller.
- sdram_wr  out  1  write strobe to the controller.
- sdram_addr  out  ADDR_W  address to the controller.
- sdram_wrdata  out  DATA_W  write data to the controller.
- sdram_wait  in  1  controller wait.
- sdram_ac  in  1  controller accept pulse.
- sdram_rddata  in  DATA_W  read data from the controller.

Behaviour:
- want[i] = req_rd[i] | req_wr[i] | req_busy[i].
- States:
  - IDLE: no owner.
  - OWN: grant is registered and non-zero.
  - GAP: one cycle with no owner between two owners.
- Reset (reset==0 at a clk edge):
  - state=IDLE, grant=0, hold_cnt=0, rr_ptr=1.
  - Outputs: sdram_rd/wr=0, sdram_addr=0, sdram_wrdata=0, req_ac=0, req_wait=all ones.
  - Any in-flight command is abandoned; requesters see wait=1.
- Arbitration (evaluated in IDLE and GAP):
  - If want[0], winner=0.
  - Otherwise, winner is the first wanting index in 1..NREQ-1 searching upward from rr_ptr with wrap-around.
  - If any want: grant<=onehot(winner), hold_cnt<=0, and rr_ptr<=winner+1 (wrapping NREQ to 1) when winner!=0. Next state OWN.
  - If no want: stay in / go to IDLE.
  - Latency: want asserted at cycle t in IDLE gives grant at t+1, and the owner's strobe reaches the controller at t+1.
- OWN datapath (combinational from the grant register):
  - sdram_rd/wr/addr/wrdata = the owner's signals.
  - req_wait[owner] = sdram_wait; req_ac[owner] = sdram_ac.
  - Non-owners: req_wait=1, req_ac=0.
  - req_rddata = sdram_rddata always; only the owner's ac qualifies it.
- hold_cnt increments on each sdram_ac in OWN and saturates at MAX_HOLD.
- Release boundary: the owner's req_rd==0 and req_wr==0 in the current cycle. A strobe held awaiting ac is never cut.
- OWN leaves to GAP at a release boundary when any of the following holds:
  - a) want[owner]==0.
  - b) owner!=0 and want[0]==1 (display preemption; hold limit ignored).
  - c) owner!=0, hold_cnt==MAX_HOLD, and another engine wants.
  - Requester 0 is never preempted by engines and yields only via (a).
- GAP: grant=0, all strobes to the controller are 0, and all req_wait=1. Arbitrates as above.
- A preempted engine still holding busy sees wait=1. It pauses and is rescheduled through round-robin.
- Simultaneous events:
  - A boundary cycle with sdram_ac=1 counts the ac first; hold_cnt may reach MAX_HOLD in that same cycle.
  - Requests arriving during GAP are eligible in that GAP cycle.
- sdram_ac outside OWN is ignored and not forwarded.
- grant is always one-hot or zero.

Test Plan:
- Single engine: req 1 busy, alternating rd/wr, controller acks each after 2 cycles → grant=3'b010 one cycle after busy; every ac is forwarded only to req_ac[1]; addresses and data pass unchanged; grant drops through GAP to IDLE after busy falls.
- Round-robin: reqs 1 and 2 both busy continuously, MAX_HOLD=4 → ownership alternates 1,2,1,2 every 4 acks with exactly one GAP cycle between owners; no strobe is ever issued during GAP.
- Display preemption: req 1 owns mid-transfer; req 0 raises busy while req_rd[1] is held awaiting ac → the read completes (ac delivered to req 1), then GAP, then grant=3'b001; req 1 sees wait=1 until req 0 drops busy, then regains the port.
- Hold not cut mid-command: hold_cnt reaches MAX_HOLD while req_wr[1]=1 and sdram_ac=0 → no release until ac arrives and the strobe falls.
- Reset mid-operation: reset low while grant=3'b100 and sdram_rd=1 → next edge gives grant=0, sdram_rd=0, req_wait=3'b111, state IDLE; after reset high, lowest-index wanting engine from rr_ptr=1 wins.
- Controller wait: the owner sees sdram_wait=1 propagated the same cycle; non-owners see wait=1 regardless of sdram_wait.
